// File: rtl/pw_conv_stream.sv
// Pointwise (1x1) convolution on a pixel stream: each input pixel of CIN signed
// channels is multiplied by a COUT x CIN weight matrix, one output channel per cycle.
// Latency COUT+1 cycles from the input handshake cycle to m_axis_tvalid, and the minimum
// pixel period is COUT+2 cycles.
// Backpressure: input is accepted only in IDLE. The output is held in OUT until
// m_axis_tready. Define PW_CONV_RELU_EN to clamp negative results to zero.
module pw_conv_stream #(
    parameter int DATA_W = 8,
    parameter int CIN    = 32,
    parameter int COUT   = 32,
    parameter int ACC_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CIN*DATA_W-1:0]               s_axis_tdata,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    output logic [COUT*DATA_W-1:0]              m_axis_tdata,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    input  logic                                weight_wr_en,
    input  logic [$clog2(CIN*COUT)-1:0]         weight_wr_addr,
    input  logic [DATA_W-1:0]                   weight_wr_data,
    output logic                                o_intr
);

    localparam int NW  = CIN * COUT;
    localparam int AW  = $clog2(NW);
    localparam int OCW = (COUT > 1) ? $clog2(COUT) : 1;

    // Saturation bounds of a signed DATA_W result, expressed at accumulator width
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

    state_t                    state_q;
    logic [OCW-1:0]            oc_q;
    logic [CIN*DATA_W-1:0]     pix_q;
    logic signed [DATA_W-1:0]  w_q [NW];
    logic [COUT*DATA_W-1:0]    obuf_q;
    logic                      tvalid_q;
    logic                      tready_q;
    logic                      intr_q;

    logic                      addr_ok;
    logic signed [2*DATA_W-1:0] prod_d;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   sh_d;
    logic [DATA_W-1:0]         res_d;
    logic [AW-1:0]             widx_d;

    // Addresses past the end of the matrix are dropped; with a power-of-two matrix every address is valid
    generate
        if ((1 << AW) == NW) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = (32'(weight_wr_addr) < 32'(NW));
        end
    endgenerate

    // Dot product of the held pixel with weight row oc, then shift, saturate and optional ReLU
    always_comb begin
        prod_d = '0;
        widx_d = '0;
        acc_d  = '0;
        for (int i = 0; i < CIN; i++) begin
            widx_d = AW'(int'(oc_q) * CIN + i);
            prod_d = $signed(pix_q[i*DATA_W +: DATA_W]) * w_q[widx_d];
            acc_d  = acc_d + ACC_W'(prod_d);
        end
        sh_d = acc_d >>> SHIFT;
        if (sh_d > MAXV) begin
            res_d = MAXV[DATA_W-1:0];
        end else if (sh_d < MINV) begin
            res_d = MINV[DATA_W-1:0];
        end else begin
            res_d = sh_d[DATA_W-1:0];
        end
`ifdef PW_CONV_RELU_EN
        if (res_d[DATA_W-1]) begin
            res_d = '0;
        end
`else
        res_d = res_d;
`endif
    end

    // Weight matrix: writable only while IDLE, so a pixel never sees a half-updated row
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NW; k++) begin
                w_q[k] <= '0;
            end
        end else if (weight_wr_en && (state_q == IDLE) && addr_ok) begin
            w_q[weight_wr_addr] <= weight_wr_data;
        end
    end

    // Control FSM: accept a pixel, compute one output channel per cycle, then hold the result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            oc_q     <= '0;
            pix_q    <= '0;
            obuf_q   <= '0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b1;
            intr_q   <= 1'b0;
        end else begin
            intr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        pix_q    <= s_axis_tdata;
                        oc_q     <= '0;
                        tready_q <= 1'b0;
                        state_q  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    obuf_q[int'(oc_q)*DATA_W +: DATA_W] <= res_d;
                    if (oc_q == OCW'(COUT - 1)) begin
                        tvalid_q <= 1'b1;
                        intr_q   <= 1'b1;
                        state_q  <= OUT;
                    end else begin
                        oc_q <= oc_q + OCW'(1);
                    end
                end
                OUT: begin
                    if (m_axis_tready) begin
                        tvalid_q <= 1'b0;
                        tready_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    tvalid_q <= 1'b0;
                    tready_q <= 1'b1;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = obuf_q;
    assign o_intr        = intr_q;

endmodule

// File: tb/tb_pw_conv_stream.sv
// Bench for pw_conv_stream with CIN=4, COUT=2, DATA_W=8: one SHIFT=0 and one SHIFT=2 instance
// share every input, so each pixel is checked against both shift settings.
// Inputs are driven and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_pw_conv_stream;

    localparam int DW   = 8;
    localparam int CIN  = 4;
    localparam int COUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        m_tready;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    logic        s_tready0, s_tready2;
    logic [15:0] m_tdata0, m_tdata2;
    logic        m_tvalid0, m_tvalid2;
    logic        intr0, intr2;

    always #5 clk = ~clk;

    pw_conv_stream #(.DATA_W(DW), .CIN(CIN), .COUT(COUT), .ACC_W(32), .SHIFT(0)) u_dut (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
        .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0), .m_axis_tready(m_tready),
        .weight_wr_en(wr_en), .weight_wr_addr(wr_addr), .weight_wr_data(wr_data),
        .o_intr(intr0)
    );

    pw_conv_stream #(.DATA_W(DW), .CIN(CIN), .COUT(COUT), .ACC_W(32), .SHIFT(2)) u_dut_s2 (
        .clk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready2),
        .m_axis_tdata(m_tdata2), .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready),
        .weight_wr_en(wr_en), .weight_wr_addr(wr_addr), .weight_wr_data(wr_data),
        .o_intr(intr2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int intr_cnt = 0;

    // Expected {SHIFT=0 tdata, SHIFT=2 tdata}, pushed at input handshake
    logic [31:0] sb_q[$];

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] pix;
        logic [15:0] e0;
        logic [15:0] e2;
        logic [7:0]  hold;
    } vec_t;

    vec_t vt[6];

    always @(posedge clk) begin
        if (!reset && intr0) intr_cnt <= intr_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] p4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [15:0] p2(input int a, input int b);
        return {8'(b), 8'(a)};
    endfunction

    // Final form of an expected output pixel for the current build
    function automatic logic [15:0] fin(input logic [15:0] e);
        logic [15:0] r;
        r = e;
`ifdef PW_CONV_RELU_EN
        for (int o = 0; o < COUT; o++) begin
            if (r[o*8+7]) r[o*8 +: 8] = 8'h00;
        end
`endif
        return r;
    endfunction

    task automatic wr_w(input int addr, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic load(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < CIN; i++) begin
            wr_w(i, w0[i*8 +: 8]);
            wr_w(CIN + i, w1[i*8 +: 8]);
        end
    endtask

    // wr_mode: 0 none, 1 weight write in the handshake cycle, 2 weight write in the first COMPUTE cycle
    task automatic send(input string nm, input logic [31:0] pix, input logic [15:0] e0,
                        input logic [15:0] e2, input int hold, input int wr_mode,
                        input int wa, input logic [7:0] wd);
        int n;
        int lat;
        int ic;
        logic [15:0] t0;
        logic [31:0] ep;
        s_tdata  = pix;
        s_tvalid = 1'b1;
        if (wr_mode == 1) begin
            wr_en = 1'b1; wr_addr = 3'(wa); wr_data = wd;
        end
        n = 0;
        while (!s_tready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " accept"}, int'(n < 50), 1);
        sb_q.push_back({fin(e0), fin(e2)});
        ic = intr_cnt;
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tdata  = ~pix;
        wr_en    = 1'b0;
        chk({nm, " busy tready"}, int'(s_tready0), 0);
        if (wr_mode == 2) begin
            wr_en = 1'b1; wr_addr = 3'(wa); wr_data = wd;
        end
        lat = 1;
        while (!m_tvalid0 && lat < 100) begin
            @(negedge clk);
            wr_en = 1'b0;
            lat++;
        end
        wr_en = 1'b0;
        chk({nm, " latency"}, lat, COUT + 1);
        chk({nm, " intr"}, int'(intr0), 1);
        chk({nm, " s2 valid"}, int'(m_tvalid2), 1);
        t0 = m_tdata0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, int'(m_tvalid0), 1);
            chk({nm, " hold data"}, int'(m_tdata0), int'(t0));
            chk({nm, " hold tready"}, int'(s_tready0), 0);
            chk({nm, " hold intr"}, int'(intr0), 0);
        end
        m_tready = 1'b1;
        if (sb_q.size() == 0) begin
            chk({nm, " sb nonempty"}, 0, 1);
            ep = '0;
        end else begin
            ep = sb_q.pop_front();
        end
        chk({nm, " data s0"}, int'(m_tdata0), int'(ep[31:16]));
        chk({nm, " data s2"}, int'(m_tdata2), int'(ep[15:0]));
        @(negedge clk);
        m_tready = 1'b0;
        chk({nm, " valid drop"}, int'(m_tvalid0), 0);
        chk({nm, " tready back"}, int'(s_tready0), 1);
        chk({nm, " intr count"}, intr_cnt - ic, 1);
    endtask

    initial begin
        int ic;
        vt[0] = '{w0: p4(1,1,1,1),         w1: p4(1,-1,2,0),          pix: p4(1,2,3,4),
                  e0: p2(10,5),    e2: p2(2,1),       hold: 8'd10};
        vt[1] = '{w0: p4(127,127,127,127), w1: p4(-127,-127,-127,-127), pix: p4(127,127,127,127),
                  e0: p2(127,-128), e2: p2(127,-128), hold: 8'd0};
        vt[2] = '{w0: p4(-127,-127,-127,-127), w1: p4(0,0,0,0),      pix: p4(127,127,127,127),
                  e0: p2(-128,0),  e2: p2(-128,0),    hold: 8'd3};
        vt[3] = '{w0: p4(1,1,1,1),         w1: p4(-1,0,0,0),          pix: p4(-5,0,0,0),
                  e0: p2(-5,5),    e2: p2(-2,1),      hold: 8'd0};
        vt[4] = '{w0: p4(2,-3,4,-5),       w1: p4(-1,-1,-1,-1),       pix: p4(10,-20,30,-40),
                  e0: p2(127,20),  e2: p2(100,5),     hold: 8'd0};
        vt[5] = '{w0: p4(3,0,0,0),         w1: p4(0,0,0,-7),          pix: p4(-9,5,6,7),
                  e0: p2(-27,-49), e2: p2(-7,-13),    hold: 8'd0};

        reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset tready", int'(s_tready0), 1);
        chk("reset tvalid", int'(m_tvalid0), 0);
        chk("reset tdata", int'(m_tdata0), 0);
        chk("reset intr", int'(intr0), 0);

        for (int i = 0; i < 6; i++) begin
            load(vt[i].w0, vt[i].w1);
            send($sformatf("vec%0d", i), vt[i].pix, vt[i].e0, vt[i].e2, int'(vt[i].hold), 0, 0, 8'd0);
        end

        // Weight write while computing is ignored; the same write in IDLE takes effect
        load(p4(1,1,1,1), p4(1,-1,2,0));
        send("wr_compute", p4(1,2,3,4), p2(10,5), p2(2,1), 0, 2, 0, 8'd50);
        send("old_weight", p4(1,2,3,4), p2(10,5), p2(2,1), 0, 0, 0, 8'd0);
        wr_w(0, 8'd50);
        send("new_weight", p4(1,2,3,4), p2(59,5), p2(14,1), 0, 0, 0, 8'd0);
        // Write coinciding with the handshake is used by that pixel: W[1][0]=10
        send("wr_with_hs", p4(1,2,3,4), p2(59,14), p2(14,3), 0, 1, 4, 8'd10);

        // Reset in the first COMPUTE cycle discards the pixel and clears weights
        s_tdata = p4(1,2,3,4); s_tvalid = 1'b1;
        ic = intr_cnt;
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("rst busy", int'(s_tready0), 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("rst no valid", int'(m_tvalid0), 0);
            chk("rst no intr", int'(intr0), 0);
            @(negedge clk);
        end
        chk("rst tready", int'(s_tready0), 1);
        chk("rst tdata", int'(m_tdata0), 0);
        chk("rst intr count", intr_cnt - ic, 0);
        send("post_rst", p4(1,2,3,4), p2(0,0), p2(0,0), 0, 0, 0, 8'd0);

        chk("sb empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pw_conv_stream.md
PW_CONV_STREAM -- requirements
Module: pw_conv_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning element width (signed two's complement).
REQ-002 SHALL have parameter CIN, default 32, meaning input channels per pixel.
REQ-003 SHALL have parameter COUT, default 32, meaning output channels per pixel.
REQ-004 SHALL have parameter ACC_W, default 32, meaning accumulator width.
REQ-005 SHALL have parameter SHIFT, default 0, meaning arithmetic right-shift applied to the accumulator before saturation.
REQ-006 SHALL have port clk, input, 1, meaning the single clock: one clock; reset is synchronous and active-high.
REQ-007 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port s_axis_tdata, input, CIN*DATA_W, meaning the input pixel; channel i is in bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port s_axis_tvalid, input, 1, meaning input valid.
REQ-010 SHALL have port s_axis_tready, output, 1, meaning input ready.
REQ-011 SHALL have port m_axis_tdata, output, COUT*DATA_W, meaning the output pixel; channel o is in bits [o*DATA_W +: DATA_W].
REQ-012 SHALL have port m_axis_tvalid, output, 1, meaning output valid.
REQ-013 SHALL have port m_axis_tready, input, 1, meaning output ready.
REQ-014 SHALL have port weight_wr_en, input, 1, meaning weight write strobe.
REQ-015 SHALL have port weight_wr_addr, input, $clog2(CIN*COUT), meaning address o*CIN+i.
REQ-016 SHALL have port weight_wr_data, input, DATA_W, meaning the signed weight.
REQ-017 SHALL have port o_intr, output, 1, meaning a one-cycle pulse on each rising edge of m_axis_tvalid.

Function
REQ-018 SHALL implement FSM states IDLE, COMPUTE and OUT.
REQ-019 SHALL drive s_axis_tready=1 only in IDLE.
REQ-020 SHALL, on an IDLE handshake (tvalid&&tready), register the input vector, clear the output channel counter oc, and enter COMPUTE.
REQ-021 SHALL in COMPUTE, each cycle, compute acc=sum over i of pix[i]*W[oc][i] (full signed, ACC_W wide) using CIN parallel multipliers, and write the result for channel oc into the output buffer.
REQ-022 SHALL derive each result as acc>>>SHIFT, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-023 SHALL increment oc each cycle in COMPUTE and enter OUT after oc=COUT-1; COMPUTE lasts exactly COUT cycles.
REQ-024 SHALL drive m_axis_tvalid=1 in OUT, with m_axis_tdata holding the full buffer, stable until the handshake.
REQ-025 SHALL return from OUT to IDLE on the cycle after m_axis_tvalid&&m_axis_tready, and hold OUT indefinitely while m_axis_tready=0.
REQ-026 SHALL give a latency of COUT+1 cycles from the input handshake edge to m_axis_tvalid=1; minimum pixel period is COUT+2 cycles.
REQ-027 SHALL ignore weight writes when the state is not IDLE; in IDLE a write updates W on that edge and is used by the next pixel.
REQ-028 SHALL, when a weight write and an input handshake occur in the same IDLE cycle, apply the write and use the new weight for that pixel.
REQ-029 SHALL ignore out-of-range weight_wr_addr values (>=CIN*COUT).
REQ-030 SHALL assert o_intr for one cycle on the first OUT cycle of each pixel (m_axis_tvalid 0->1).

Reset
REQ-031 SHALL on reset force state=IDLE, oc=0, m_axis_tvalid=0, m_axis_tdata=0, output buffer=0, o_intr=0 and all weights=0; s_axis_tready=1 on the first cycle after reset.
REQ-032 SHALL, on reset asserted mid-COMPUTE or mid-OUT, discard the pixel with no output transfer.

Configuration
REQ-033 SHALL support macro PW_CONV_RELU_EN: when defined, each saturated result below 0 is replaced with 0 (fused ReLU); when undefined, signed saturated results pass unchanged; timing is identical in both cases.

Verification
REQ-034 SHALL pass: CIN=4, COUT=2, SHIFT=0, W[0]={1,1,1,1}, W[1]={1,-1,2,0}, pixel {1,2,3,4} -> output {ch0=10, ch1=5}, m_axis_tvalid rises exactly 3 cycles after the handshake, with o_intr pulsed once.
REQ-035 SHALL pass: W[0]={127,127,127,127}, pixel {127,127,127,127} -> ch0=127 (saturated); W[0] negated -> ch0=-128, or 0 with PW_CONV_RELU_EN.
REQ-036 SHALL pass: m_axis_tready held 0 for 10 cycles in OUT -> tvalid and tdata stable, s_axis_tready=0, and the next pixel is accepted only after the handshake plus 1 cycle.
REQ-037 SHALL pass: a weight write to addr 0 during COMPUTE -> ignored, and the next pixel uses the old weight; the same write in IDLE -> the new weight is used.
REQ-038 SHALL pass: reset asserted in cycle 1 of COMPUTE -> no output, m_axis_tvalid=0, weights zero, and a following pixel yields all-zero output.
REQ-039 SHALL pass: SHIFT=2, acc=-5 -> result -2 (arithmetic shift, floor).
